// File: rtl/rv32i_types_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv32i_types_pkg : shared types for the cache flush sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package rv32i_types_pkg;

  localparam int unsigned c_drain_timeout_default = 255;
  localparam int unsigned c_drain_cnt_w_default   = 8;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DRAIN       = 3'd1,
    DFLUSH_REQ  = 3'd2,
    DFLUSH_WAIT = 3'd3,
    IFLUSH_REQ  = 3'd4,
    IFLUSH_WAIT = 3'd5,
    DONE        = 3'd6,
    HALTED      = 3'd7
  } flush_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/flush_drain_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// flush_drain_counter : saturating DRAIN cycle counter with terminal flag
// Rev 1.0
// ----------------------------------------------------------------------------
module flush_drain_counter #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W:0] c_limit = (CNT_W+1)'(LIMIT);
  localparam logic [CNT_W:0] c_one   = (CNT_W+1)'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_cnt_inc;

  assign w_cnt_inc = {1'b0, r_cnt} + c_one;

  // Counter holds the DRAIN cycles already spent; tc marks the cycle that completes LIMIT of them.
  assign tc = en && (w_cnt_inc >= c_limit);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != '1)) begin
      r_cnt <= w_cnt_inc[CNT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_flush_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_flush_sequencer : drains the pipe, flushes D$/I$ for halt and fence.i
// Rev 1.0
// ----------------------------------------------------------------------------
module cache_flush_sequencer
  import rv32i_types_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT = c_drain_timeout_default,
  parameter int unsigned CNT_W         = c_drain_cnt_w_default
) (
  input  logic CLK,
  input  logic nRST,
  input  logic halt_req,
  input  logic ifence_req,
  input  logic pipe_idle,
  input  logic dflush_done,
  input  logic iflush_done,
  output logic pipe_stall,
  output logic dflush,
  output logic iflush,
  output logic ifence_done,
  output logic halt,
  output logic drain_timeout
);

  flush_seq_state_t r_state;
  flush_seq_state_t w_state_nxt;

  logic r_halt_pend;
  logic r_pipe_stall;
  logic r_dflush;
  logic r_iflush;
  logic r_ifence_done;
  logic r_halt;
  logic r_drain_timeout;
  logic w_in_drain;
  logic w_drain_tc;
  logic w_halt_eff;

  assign w_in_drain = (r_state == DRAIN);
  // A halt seen in the completion cycle itself still diverts the sequence to HALTED.
  assign w_halt_eff = r_halt_pend | halt_req;

  flush_drain_counter #(
    .CNT_W (CNT_W),
    .LIMIT (DRAIN_TIMEOUT)
  ) u_drain_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (!w_in_drain),
    .en   (w_in_drain),
    .tc   (w_drain_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:        if (halt_req || ifence_req) w_state_nxt = DRAIN;
      DRAIN:       if (pipe_idle || w_drain_tc) w_state_nxt = DFLUSH_REQ;
      DFLUSH_REQ:  w_state_nxt = DFLUSH_WAIT;
      DFLUSH_WAIT: if (dflush_done) w_state_nxt = w_halt_eff ? HALTED : IFLUSH_REQ;
      IFLUSH_REQ:  w_state_nxt = IFLUSH_WAIT;
      IFLUSH_WAIT: if (iflush_done) w_state_nxt = w_halt_eff ? HALTED : DONE;
      DONE:        w_state_nxt = IDLE;
      HALTED:      w_state_nxt = HALTED;
      default:     w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state         <= IDLE;
      r_halt_pend     <= 1'b0;
      r_pipe_stall    <= 1'b0;
      r_dflush        <= 1'b0;
      r_iflush        <= 1'b0;
      r_ifence_done   <= 1'b0;
      r_halt          <= 1'b0;
      r_drain_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pipe_stall  <= (w_state_nxt != IDLE);
      r_dflush      <= (w_state_nxt == DFLUSH_REQ);
      r_iflush      <= (w_state_nxt == IFLUSH_REQ);
      r_ifence_done <= (w_state_nxt == DONE);
      r_halt        <= (w_state_nxt == HALTED);
      if (w_in_drain && w_drain_tc && !pipe_idle) begin
        r_drain_timeout <= 1'b1;
      end
      case (r_state)
        IDLE:    r_halt_pend <= halt_req;
        HALTED:  r_halt_pend <= r_halt_pend;
        default: if (halt_req) r_halt_pend <= 1'b1;
      endcase
    end
  end

  assign pipe_stall    = r_pipe_stall;
  assign dflush        = r_dflush;
  assign iflush        = r_iflush;
  assign ifence_done   = r_ifence_done;
  assign halt          = r_halt;
  assign drain_timeout = r_drain_timeout;

endmodule
`default_nettype wire

// File: tb/tb_cache_flush_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cache_flush_sequencer : randomized scoreboard bench for the flush sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cache_flush_sequencer;

  localparam int T = 4;

  localparam int EV_STALL_RISE = 0;
  localparam int EV_DFLUSH     = 1;
  localparam int EV_IFLUSH     = 2;
  localparam int EV_IFDONE     = 3;
  localparam int EV_HALT       = 4;
  localparam int EV_STALL_FALL = 5;
  localparam int EV_HALT_FALL  = 6;

  logic CLK = 1'b0;
  logic nRST = 1'b1;
  logic halt_req = 1'b0;
  logic ifence_req = 1'b0;
  logic pipe_idle = 1'b0;
  logic dflush_done = 1'b0;
  logic iflush_done = 1'b0;
  logic pipe_stall, dflush, iflush, ifence_done, halt, drain_timeout;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t  exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic exp_tmo = 1'b0;
  logic p_stall = 1'b0;
  logic p_halt = 1'b0;

  cache_flush_sequencer #(
    .DRAIN_TIMEOUT (T),
    .CNT_W         (8)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .halt_req      (halt_req),
    .ifence_req    (ifence_req),
    .pipe_idle     (pipe_idle),
    .dflush_done   (dflush_done),
    .iflush_done   (iflush_done),
    .pipe_stall    (pipe_stall),
    .dflush        (dflush),
    .iflush        (iflush),
    .ifence_done   (ifence_done),
    .halt          (halt),
    .drain_timeout (drain_timeout)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic string ev_name(input int k);
    case (k)
      EV_STALL_RISE: return "stall_rise";
      EV_DFLUSH:     return "dflush";
      EV_IFLUSH:     return "iflush";
      EV_IFDONE:     return "ifence_done";
      EV_HALT:       return "halt_rise";
      EV_STALL_FALL: return "stall_fall";
      EV_HALT_FALL:  return "halt_fall";
      default:       return "none";
    endcase
  endfunction

  function automatic logic rnd_bit();
    int x;
    x = $urandom_range(1, 0);
    return (x != 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic see_event(input int k);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event: got %s at cycle %0d, required no event", ev_name(k), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
        n_err++;
        $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                 ev_name(k), cyc, ev_name(e.kind), e.cyc);
      end
    end
  endtask

  task automatic push_ev(input int k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every output edge/pulse is matched against the next expected event.
  always @(negedge CLK) begin
    if (!nRST) begin
      p_stall = 1'b0;
      p_halt  = 1'b0;
    end else begin
      if (pipe_stall !== p_stall) see_event(pipe_stall ? EV_STALL_RISE : EV_STALL_FALL);
      if (dflush)      see_event(EV_DFLUSH);
      if (iflush)      see_event(EV_IFLUSH);
      if (ifence_done) see_event(EV_IFDONE);
      if (halt !== p_halt) see_event(halt ? EV_HALT : EV_HALT_FALL);
      p_stall = pipe_stall;
      p_halt  = halt;
    end
  end

  task automatic do_reset();
    check("events_pending_before_reset", exp_q.size(), 0);
    nRST        = 1'b0;
    halt_req    = 1'b0;
    ifence_req  = 1'b0;
    pipe_idle   = 1'b0;
    dflush_done = 1'b0;
    iflush_done = 1'b0;
    #1;
    check("rst_pipe_stall", pipe_stall, 0);
    check("rst_dflush", dflush, 0);
    check("rst_iflush", iflush, 0);
    check("rst_ifence_done", ifence_done, 0);
    check("rst_halt", halt, 0);
    check("rst_drain_timeout", drain_timeout, 0);
    exp_tmo = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    #2 nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // kind: 0 fence.i, 1 halt, 2 halt+fence.i together, 3 fence.i then halt early,
  //       4 fence.i then halt in IFLUSH_WAIT, 5 fence.i cut by reset in DFLUSH_WAIT
  task automatic run_txn(input int kind, input int d_idle, input int dd, input int di);
    int t0, L, rdf, rdd, rif, rid, rh, rr, len;
    bit halts, has_halt, tmo;
    t0       = cyc;
    L        = (d_idle + 1 < T) ? d_idle + 1 : T;
    tmo      = (d_idle >= T);
    rdf      = 1 + L;
    rdd      = rdf + 1 + dd;
    rif      = rdd + 1;
    rid      = rif + 1 + di;
    rh       = 0;
    rr       = 0;
    halts    = (kind >= 1 && kind <= 3);
    has_halt = (kind >= 1 && kind <= 4);
    if (kind == 3) rh = $urandom_range(rdf, 1);
    if (kind == 4) rh = rif + 1 + $urandom_range(di - 1, 0);
    if (kind == 5) rr = $urandom_range(rdd - 1, rdf + 1);

    push_ev(EV_STALL_RISE, t0 + 1);
    push_ev(EV_DFLUSH, t0 + rdf);
    if (halts) begin
      push_ev(EV_HALT, t0 + rdd + 1);
      len = rdd + 5;
    end else if (kind == 5) begin
      len = rr;
    end else begin
      push_ev(EV_IFLUSH, t0 + rif);
      if (kind == 4) begin
        push_ev(EV_HALT, t0 + rid + 1);
        len = rid + 5;
      end else begin
        push_ev(EV_IFDONE, t0 + rid + 1);
        push_ev(EV_STALL_FALL, t0 + rid + 2);
        len = rid + 2;
      end
    end
    exp_tmo = exp_tmo | tmo;

    for (int r = 0; r < len; r++) begin
      if (r == 0) ifence_req = (kind != 1);
      else        ifence_req = ($urandom_range(3, 0) == 0);
      halt_req = has_halt && (r >= rh);
      if (r >= 1 && r <= L) pipe_idle = (r > d_idle);
      else                  pipe_idle = rnd_bit();
      if (r >= rdf + 1 && r <= rdd) dflush_done = (r == rdd);
      else                          dflush_done = rnd_bit();
      if (!halts && r >= rif + 1 && r <= rid) iflush_done = (r == rid);
      else                                    iflush_done = rnd_bit();
      @(posedge CLK);
      #1;
    end

    check("drain_timeout", drain_timeout, exp_tmo);
    if (has_halt) begin
      check("halt_held", halt, 1);
      check("stall_in_halted", pipe_stall, 1);
      do_reset();
    end else if (kind == 5) begin
      check("stall_in_dflush_wait", pipe_stall, 1);
      do_reset();
    end
  endtask

  initial begin
    int kind, d_idle, dd, di;
    #1 nRST = 1'b0;
    #1;
    check("init_pipe_stall", pipe_stall, 0);
    check("init_dflush", dflush, 0);
    check("init_iflush", iflush, 0);
    check("init_ifence_done", ifence_done, 0);
    check("init_halt", halt, 0);
    check("init_drain_timeout", drain_timeout, 0);
    @(negedge CLK);
    #2 nRST = 1'b1;
    @(posedge CLK);
    #1;

    run_txn(1, 0, 0, 0);
    run_txn(0, 0, 0, 0);
    run_txn(1, 6, 1, 0);
    run_txn(4, 1, 1, 2);
    run_txn(2, 0, 0, 0);
    run_txn(5, 0, 3, 0);
    run_txn(0, 0, 0, 0);
    run_txn(0, 5, 2, 1);
    run_txn(0, 2, 0, 3);
    run_txn(3, 1, 1, 1);

    for (int i = 0; i < 40; i++) begin
      kind   = $urandom_range(5, 0);
      d_idle = $urandom_range(6, 0);
      dd     = (kind == 5) ? $urandom_range(4, 2) : $urandom_range(3, 0);
      di     = (kind == 4) ? $urandom_range(3, 1) : $urandom_range(3, 0);
      run_txn(kind, d_idle, dd, di);
      if (kind == 5) run_txn(0, $urandom_range(6, 0), $urandom_range(3, 0), $urandom_range(3, 0));
    end

    halt_req    = 1'b0;
    ifence_req  = 1'b0;
    pipe_idle   = 1'b0;
    dflush_done = 1'b0;
    iflush_done = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("events_left_over", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
